// File: rtl/cm0_dap_jt_cdc_defs_pkg.sv
// Shared definitions for the DAP 4-phase REQ/ACK CDC blocks (send and receive sides).
package cm0_dap_jt_cdc_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_ACK  = 2'b10
  } cdc_st_e;

  localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/cm0_dap_jt_cdc_sync.sv
// Single-bit request synchroniser; stands in for the library synchroniser cell.
module cm0_dap_jt_cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic dclk,
  input  logic dreset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge dclk) begin
    if (dreset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cm0_dap_jt_cdc_req_rx.sv
// Receive side of the DAP 4-phase REQ/ACK CDC: synchronise REQ, capture data,
// present it as a VALID/READY word and return a flop-driven ACK.
module cm0_dap_jt_cdc_req_rx
  import cm0_dap_jt_cdc_defs::*;
#(
  parameter int PRESENT     = 1,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          dclk,
  input  logic          dreset,
  input  logic          reqin,
  input  logic [DW-1:0] datain,
  output logic          validout,
  output logic [DW-1:0] dataout,
  input  logic          readyin,
  output logic          ackout,
  output logic          abort
);

  localparam int SS = (SYNC_STAGES < CDC_MIN_SYNC_STAGES) ? CDC_MIN_SYNC_STAGES : SYNC_STAGES;

  if (PRESENT != 0) begin : g_present
    logic          reqs;
    logic [SS-1:0] fill;
    logic          armed;
    cdc_st_e       st;
    logic          valid_q, ack_q, abort_q;
    logic [DW-1:0] data_q;

    cm0_dap_jt_cdc_sync #(.STAGES(SS)) u_sync (
      .dclk   (dclk),
      .dreset (dreset),
      .d      (reqin),
      .q      (reqs)
    );

    // The chain is flushed to 0 by reset, so a low reqs only counts as a real
    // observation of REQIN once the chain has refilled with post-reset samples.
    always_ff @(posedge dclk) begin
      if (dreset) begin
        fill  <= '0;
        armed <= 1'b0;
      end else begin
        fill <= {fill[SS-2:0], 1'b1};
        if (fill[SS-1] && !reqs) armed <= 1'b1;
      end
    end

    always_ff @(posedge dclk) begin
      if (dreset) begin
        st      <= ST_IDLE;
        valid_q <= 1'b0;
        ack_q   <= 1'b0;
        abort_q <= 1'b0;
        data_q  <= '0;
      end else begin
        abort_q <= 1'b0;
        case (st)
          ST_IDLE: if (reqs && armed) begin
            st      <= ST_HOLD;
            data_q  <= datain;
            valid_q <= 1'b1;
          end
          ST_HOLD: if (readyin) begin
            valid_q <= 1'b0;
            if (reqs) begin
              ack_q <= 1'b1;
              st    <= ST_ACK;
            end else begin
              // Sender withdrew in the same cycle the word was taken: the
              // transfer stands, but there is no request left to acknowledge.
              st <= ST_IDLE;
            end
          end else if (!reqs) begin
            valid_q <= 1'b0;
            abort_q <= 1'b1;
            st      <= ST_IDLE;
          end
          ST_ACK: if (!reqs) begin
            ack_q <= 1'b0;
            st    <= ST_IDLE;
          end
          default: st <= ST_IDLE;
        endcase
      end
    end

    assign validout = valid_q;
    assign dataout  = data_q;
    assign ackout   = ack_q;
    assign abort    = abort_q;
  end else begin : g_absent
    logic unused_inputs;
    assign unused_inputs = ^{dclk, dreset, reqin, datain, readyin};
    assign validout = 1'b0;
    assign dataout  = '0;
    assign ackout   = 1'b0;
    assign abort    = 1'b0;
  end

endmodule

// File: tb/tb_cm0_dap_jt_cdc_req_rx.sv
// Bench for cm0_dap_jt_cdc_req_rx: directed handshake scenarios plus random
// sender/consumer traffic against a cycle-level transaction model.
module tb_cm0_dap_jt_cdc_req_rx;

  logic        dclk = 1'b0;
  logic        dreset = 1'b1;
  logic        reqin = 1'b0;
  logic [31:0] datain = '0;
  logic        readyin = 1'b0;

  logic        v0, a0, ab0, v3, a3, ab3, vp, ap, abp;
  logic [31:0] d0, d3, dp;

  int vectors = 0;
  int miscompares = 0;

  always #5 dclk = ~dclk;

  cm0_dap_jt_cdc_req_rx #(.PRESENT(1), .DW(32), .SYNC_STAGES(2)) u0 (
    .dclk(dclk), .dreset(dreset), .reqin(reqin), .datain(datain), .validout(v0),
    .dataout(d0), .readyin(readyin), .ackout(a0), .abort(ab0));

  cm0_dap_jt_cdc_req_rx #(.PRESENT(1), .DW(32), .SYNC_STAGES(3)) u3 (
    .dclk(dclk), .dreset(dreset), .reqin(reqin), .datain(datain), .validout(v3),
    .dataout(d3), .readyin(readyin), .ackout(a3), .abort(ab3));

  cm0_dap_jt_cdc_req_rx #(.PRESENT(0), .DW(32), .SYNC_STAGES(2)) up (
    .dclk(dclk), .dreset(dreset), .reqin(reqin), .datain(datain), .validout(vp),
    .dataout(dp), .readyin(readyin), .ackout(ap), .abort(abp));

  // Model: index 0 = 2-stage instance, index 1 = 3-stage instance.
  bit          m_v[2], m_a[2], m_ab[2], m_arm[2];
  logic [31:0] m_w[2];
  bit   [7:0]  m_sh[2];   // REQIN samples, bit 0 = most recent edge
  int          m_n[2];    // edges since reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input int i, input int s);
    bit warm, rq;
    if (dreset) begin
      m_v[i] = 0; m_a[i] = 0; m_ab[i] = 0; m_arm[i] = 0;
      m_w[i] = '0; m_sh[i] = '0; m_n[i] = 0;
      return;
    end
    warm = (m_n[i] >= s);
    rq   = warm ? m_sh[i][s-1] : 1'b0;
    m_ab[i] = 0;
    if (m_v[i]) begin
      if (readyin) begin
        m_v[i] = 0;
        m_a[i] = rq;
      end else if (!rq) begin
        m_v[i]  = 0;
        m_ab[i] = 1;
      end
    end else if (m_a[i]) begin
      if (!rq) m_a[i] = 0;
    end else if (rq && m_arm[i]) begin
      m_v[i] = 1;
      m_w[i] = datain;
    end
    if (warm && !rq) m_arm[i] = 1;
    m_sh[i] = {m_sh[i][6:0], reqin};
    if (m_n[i] < 100) m_n[i]++;
  endtask

  task automatic compare_all();
    chk("s2.valid", {31'd0, v0},  {31'd0, m_v[0]});
    chk("s2.ack",   {31'd0, a0},  {31'd0, m_a[0]});
    chk("s2.abort", {31'd0, ab0}, {31'd0, m_ab[0]});
    chk("s2.data",  d0, m_w[0]);
    chk("s3.valid", {31'd0, v3},  {31'd0, m_v[1]});
    chk("s3.ack",   {31'd0, a3},  {31'd0, m_a[1]});
    chk("s3.abort", {31'd0, ab3}, {31'd0, m_ab[1]});
    chk("s3.data",  d3, m_w[1]);
    chk("absent.outs", {dp[28:0], vp, ap, abp}, 32'd0);
    chk("absent.outs_hi", {29'd0, dp[31:29]}, 32'd0);
  endtask

  // Drive one cycle's inputs, advance the model, compare after the edge.
  task automatic tick(input bit r, input logic [31:0] d, input bit rdy, input bit rst);
    reqin = r; datain = d; readyin = rdy; dreset = rst;
    model_step(0, 2);
    model_step(1, 3);
    @(negedge dclk);
    compare_all();
  endtask

  initial begin
    logic [31:0] word;
    bit r, rdy, rst;

    // Reset and arm
    tick(0, 32'h0, 0, 1);
    chk("reset.valid", {31'd0, v0}, 32'd0);
    chk("reset.ack",   {31'd0, a0}, 32'd0);
    chk("reset.data",  d0, 32'd0);
    tick(0, 32'h0, 0, 1);
    repeat (5) tick(0, 32'h0, 0, 0);

    // Basic transfer
    tick(1, 32'hA5A5_0F0F, 0, 0);
    tick(1, 32'hA5A5_0F0F, 0, 0);
    chk("basic.valid_e2", {31'd0, v0}, 32'd0);
    tick(1, 32'hA5A5_0F0F, 0, 0);
    chk("basic.valid_e3", {31'd0, v0}, 32'd1);
    chk("basic.data",     d0, 32'hA5A5_0F0F);
    chk("s3.valid_e3",    {31'd0, v3}, 32'd0);
    tick(1, 32'hA5A5_0F0F, 1, 0);
    chk("basic.ack",      {31'd0, a0}, 32'd1);
    chk("basic.valid_off",{31'd0, v0}, 32'd0);
    chk("s3.valid_e4",    {31'd0, v3}, 32'd1);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 0, 0);
    chk("basic.ack_held", {31'd0, a0}, 32'd1);
    tick(0, 32'h0, 0, 0);
    chk("basic.ack_drop", {31'd0, a0}, 32'd0);
    repeat (6) tick(0, 32'h0, 0, 0);

    // Back-pressure with DATAIN changing after capture
    repeat (3) tick(1, 32'h1234_5678, 0, 0);
    chk("bp.valid", {31'd0, v0}, 32'd1);
    for (int n = 0; n < 50; n++) begin
      tick(1, $urandom, 0, 0);
      chk("bp.data_hold", d0, 32'h1234_5678);
      chk("bp.valid_hold", {31'd0, v0, a0}, 32'd2);
    end
    tick(1, 32'h0, 1, 0);
    chk("bp.ack", {31'd0, a0}, 32'd1);
    repeat (8) tick(0, 32'h0, 0, 0);

    // Abort
    repeat (3) tick(1, 32'hDEAD_BEEF, 0, 0);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 0, 0);
    chk("abort.early", {31'd0, ab0}, 32'd0);
    tick(0, 32'h0, 0, 0);
    chk("abort.pulse", {30'd0, v0, ab0}, 32'd1);
    tick(0, 32'h0, 0, 0);
    chk("abort.one_cycle", {30'd0, ab0, a0}, 32'd0);
    repeat (6) tick(0, 32'h0, 0, 0);

    // Race: READY arrives in the cycle reqs falls
    repeat (3) tick(1, 32'h0BAD_F00D, 0, 0);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 0, 0);
    tick(0, 32'h0, 1, 0);
    chk("race.outs", {29'd0, v0, a0, ab0}, 32'd0);
    tick(0, 32'h0, 0, 0);
    chk("race.no_ack", {30'd0, a0, ab0}, 32'd0);
    repeat (6) tick(0, 32'h0, 0, 0);

    // Reset in HOLD, REQIN held high through reset
    repeat (3) tick(1, 32'h5555_AAAA, 0, 0);
    tick(1, 32'h5555_AAAA, 0, 1);
    chk("rst_hold.outs", {29'd0, v0, a0, ab0}, 32'd0);
    chk("rst_hold.data", d0, 32'd0);
    for (int n = 0; n < 10; n++) begin
      tick(1, 32'h5555_AAAA, 1, 0);
      chk("rst_hold.no_valid", {31'd0, v0}, 32'd0);
    end
    repeat (4) tick(0, 32'h0, 0, 0);
    repeat (3) tick(1, 32'h7777_0001, 0, 0);
    chk("rearm.valid", {31'd0, v0}, 32'd1);
    tick(1, 32'h7777_0001, 1, 0);
    chk("rearm.ack", {31'd0, a0}, 32'd1);
    tick(1, 32'h7777_0001, 0, 1);
    chk("rst_ack.outs", {29'd0, v0, a0, ab0}, 32'd0);
    repeat (8) tick(0, 32'h0, 0, 0);

    // Random sender / consumer traffic
    r = 0; word = '0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!r && !a0)     r = ($urandom_range(0, 3) == 0);
      else if (r && a0)  r = ($urandom_range(0, 1) == 0);
      else if (r)        r = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 3) == 0) word = $urandom;
      rdy = $urandom_range(0, 1);
      tick(r, word, rdy, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
